// File: rtl/fifo_wr_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// fifo_arb_pkg
// Shared definitions for the shared-FIFO write arbiter:
//   - arb_state_t  : arbiter FSM state (IDLE / BURST)
//   - DEF_*        : default parameter values used by the interface and RTL
//   - owner_width  : width of a requester index (at least one bit)
// ---------------------------------------------------------------------------
package fifo_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_t;

    localparam int DEF_NUM_REQ    = 4;
    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_MAX_BURST  = 4;

    function automatic int owner_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// ---------------------------------------------------------------------------
// fifo_wr_arbiter_if
// Bundles the requester side and the shared-FIFO write side of the arbiter.
//   req_valid [NUM_REQ]            per-requester word available
//   req_data  [NUM_REQ*DATA_WIDTH] packed requester data, slice i = requester i
//   req_ready [NUM_REQ]            per-requester accept (one-hot or zero)
//   full                           shared FIFO full flag
//   wr / w_data                    write strobe and data to the shared FIFO
//   owner                          index of the currently granted requester
//   busy                           high while a burst is in progress
// Modports:
//   master : the arbiter itself
//   slave  : the environment (requesters plus the FIFO controller)
// ---------------------------------------------------------------------------
interface fifo_wr_arbiter_if
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ    = DEF_NUM_REQ,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
);
    localparam int OWNER_W = owner_width(NUM_REQ);

    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            req_ready;
    logic                          full;
    logic                          wr;
    logic [DATA_WIDTH-1:0]         w_data;
    logic [OWNER_W-1:0]            owner;
    logic                          busy;

    modport master (
        input  req_valid, req_data, full,
        output req_ready, wr, w_data, owner, busy
    );

    modport slave (
        output req_valid, req_data, full,
        input  req_ready, wr, w_data, owner, busy
    );

endinterface

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
// Combinational round-robin selector: searches i_req starting at i_start,
// wrapping modulo N, and returns the first set index.
//   i_req   [N]   request vector
//   i_start [IW]  index searched first (must be < N)
//   o_found       any request set
//   o_idx   [IW]  selected index (0 when nothing is found)
// ---------------------------------------------------------------------------
module rr_pick
    import fifo_arb_pkg::*;
#(
    parameter int N  = DEF_NUM_REQ,
    parameter int IW = owner_width(N)
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_start,
    output logic          o_found,
    output logic [IW-1:0] o_idx
);

    // One spare bit so start + offset cannot overflow before the wrap.
    logic [IW:0] w_cand;

    always_comb begin
        o_found = 1'b0;
        o_idx   = '0;
        w_cand  = '0;
        for (int k = 0; k < N; k++) begin
            w_cand = {1'b0, i_start} + (IW+1)'(k);
            if (w_cand >= (IW+1)'(N)) begin
                w_cand = w_cand - (IW+1)'(N);
            end
            if (!o_found && i_req[w_cand[IW-1:0]]) begin
                o_found = 1'b1;
                o_idx   = w_cand[IW-1:0];
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// ---------------------------------------------------------------------------
// fifo_wr_arbiter
// Grants one of NUM_REQ requesters at a time write access to a shared FIFO.
// A grant is chosen round-robin in IDLE and takes effect one cycle later;
// the owner then streams up to MAX_BURST words, stalling while the FIFO is
// full and releasing early if it runs out of data.
// Ports:
//   clk    system clock, rising edge
//   reset  asynchronous, active-low reset
//   bus    fifo_wr_arbiter_if.master (requester and FIFO handshake)
// ---------------------------------------------------------------------------
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ    = DEF_NUM_REQ,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int MAX_BURST  = DEF_MAX_BURST
) (
    input  logic               clk,
    input  logic               reset,
    fifo_wr_arbiter_if.master  bus
);

    localparam int OW = owner_width(NUM_REQ);
    localparam int CW = $clog2(MAX_BURST + 1);

    arb_state_t    r_state;
    arb_state_t    w_state_nxt;
    logic [OW-1:0] r_owner;
    logic [OW-1:0] w_owner_nxt;
    logic [OW-1:0] r_last_owner;
    logic [OW-1:0] w_last_owner_nxt;
    logic [CW-1:0] r_count;
    logic [CW-1:0] w_count_nxt;
    logic [CW-1:0] w_count_inc;

    logic [OW-1:0] w_start;
    logic          w_found;
    logic [OW-1:0] w_pick;
    logic          w_busy;
    logic          w_owner_vld;
    logic          w_wr;

    // Search begins just after the last owner so every requester gets a turn.
    assign w_start = (r_last_owner == OW'(NUM_REQ - 1)) ? '0 : r_last_owner + OW'(1);

    rr_pick #(
        .N  (NUM_REQ),
        .IW (OW)
    ) u_rr_pick (
        .i_req   (bus.req_valid),
        .i_start (w_start),
        .o_found (w_found),
        .o_idx   (w_pick)
    );

    assign w_busy      = (r_state == BURST);
    assign w_owner_vld = bus.req_valid[r_owner];
    // Gating with ~full here is what guarantees the shared FIFO never overflows.
    assign w_wr        = w_busy & w_owner_vld & ~bus.full;
    assign w_count_inc = r_count + CW'(1);

    assign bus.wr     = w_wr;
    assign bus.busy   = w_busy;
    assign bus.owner  = r_owner;
    assign bus.w_data = bus.req_data[r_owner*DATA_WIDTH +: DATA_WIDTH];

    always_comb begin
        bus.req_ready = '0;
        if (w_busy && !bus.full) begin
            bus.req_ready[r_owner] = 1'b1;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_owner_nxt      = r_owner;
        w_last_owner_nxt = r_last_owner;
        w_count_nxt      = r_count;
        unique case (r_state)
            IDLE: begin
                if (w_found) begin
                    w_state_nxt = BURST;
                    w_owner_nxt = w_pick;
                    w_count_nxt = '0;
                end
            end
            BURST: begin
                if (!w_owner_vld) begin
                    // Owner ran dry: give the bus back without a transfer.
                    w_state_nxt      = IDLE;
                    w_last_owner_nxt = r_owner;
                end else if (!bus.full) begin
                    w_count_nxt = w_count_inc;
                    if (w_count_inc == CW'(MAX_BURST)) begin
                        w_state_nxt      = IDLE;
                        w_last_owner_nxt = r_owner;
                    end
                end
                // full with data pending: hold everything, no timeout.
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= IDLE;
            r_owner      <= '0;
            r_last_owner <= OW'(NUM_REQ - 1);
            r_count      <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_owner      <= w_owner_nxt;
            r_last_owner <= w_last_owner_nxt;
            r_count      <= w_count_nxt;
        end
    end

endmodule

// File: doc/fifo_wr_arbiter.md
FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4: number of requesters (2..8).
REQ-002 Parameter DATA_WIDTH, default 8: write-data width.
REQ-003 Parameter MAX_BURST, default 4: maximum words accepted per grant (1..16).
REQ-004 The module SHALL have one clock and one reset: reset is asynchronous and active-low.
REQ-005 clk  input  1  system clock; all state updates on rising edge.
REQ-006 reset  input  1  asynchronous, active-low reset (asserted at 0).
REQ-007 req_valid  input  NUM_REQ  per-requester word-available flag.
REQ-008 req_data  input  NUM_REQ*DATA_WIDTH  packed data; requester i occupies slice [i*DATA_WIDTH +: DATA_WIDTH].
REQ-009 req_ready  output  NUM_REQ  per-requester accept flag; one-hot or zero.
REQ-010 full  input  1  full flag from the shared FIFO controller.
REQ-011 wr  output  1  write strobe to the shared FIFO.
REQ-012 w_data  output  DATA_WIDTH  write data to the shared FIFO.
REQ-013 owner  output  $clog2(NUM_REQ)  index of the currently granted requester.
REQ-014 busy  output  1  high while in BURST.

Function
REQ-015 The module SHALL implement a two-state FSM, IDLE and BURST.
REQ-016 In IDLE with any req_valid high, the module SHALL pick the first valid requester searching round-robin from last_owner+1 (mod NUM_REQ), register it as owner, clear burst count, and enter BURST next cycle.
REQ-017 In IDLE with no req_valid high, the module SHALL remain in IDLE with owner unchanged.
REQ-018 In IDLE, req_ready SHALL be all zero and wr SHALL be 0 (one-cycle grant latency).
REQ-019 In BURST, req_ready[owner] SHALL equal ~full; all other req_ready bits SHALL be 0 (combinational).
REQ-020 wr SHALL equal busy & req_valid[owner] & ~full; w_data SHALL equal req_data slice of owner at all times.
REQ-021 Each cycle with wr high, the burst count SHALL increment by 1.
REQ-022 In BURST, if wr is high and the count reaches MAX_BURST after the increment, the FSM SHALL return to IDLE and last_owner SHALL become owner.
REQ-023 In BURST, if req_valid[owner] is low, the FSM SHALL return to IDLE with no transfer and last_owner SHALL become owner.
REQ-024 In BURST with full high and req_valid[owner] high, the FSM SHALL hold state, owner and count (stall, no timeout).
REQ-025 Changes on req_valid of non-owners SHALL NOT affect BURST.
REQ-026 The module SHALL never issue wr while full is high (no overflow of the shared FIFO).

Reset
REQ-027 While reset is 0: state IDLE, owner 0, last_owner NUM_REQ-1 (requester 0 has first priority), count 0; wr 0, req_ready 0, busy 0.
REQ-028 Reset asserted mid-BURST SHALL drop wr and req_ready in the same cycle; no partial state survives.

Structure
REQ-029 Package fifo_arb_pkg SHALL hold the FSM state enum (IDLE, BURST) and the default parameter constants.
REQ-030 Round-robin selection SHALL be a combinational sub-module rr_pick (inputs: request vector, start index; outputs: found flag, selected index).
REQ-031 Burst counter width SHALL be $clog2(MAX_BURST+1).

Verification
REQ-032 Reset: hold reset 0 with req_valid=4'b1111 -> wr 0, req_ready 0, busy 0, owner 0.
REQ-033 Single requester: req_valid=4'b0100, full 0, held 6 words -> owner 2, burst of 4 writes, one idle cycle, regrant to 2, 2 more writes; data order preserved.
REQ-034 Fairness: req_valid=4'b1111 always, full 0 -> grant sequence 0,1,2,3,0 with 4 writes each.
REQ-035 Back-pressure: owner 1 mid-burst, full high 3 cycles -> wr 0, req_ready 0, count held; resumes on full low, total 4 writes.
REQ-036 Early release: owner 3 drops req_valid after 2 words -> IDLE next cycle, next grant to 0 if valid.
REQ-037 Reset mid-burst: assert reset during BURST -> wr and req_ready 0 immediately; after release, first grant goes to requester 0.
